// File: rtl/img_io_ctrl.sv
// Image I/O controller: loads a received image into RAM, hands the RAM to the
// CPU, then dumps a window of the RAM back out through the UART transmitter.
//
// Handshakes: rx_done is a level that must drop between bytes; exactly one
// write is made per high period. tx_start is a one-cycle pulse; the byte is
// acknowledged by a tx_done pulse, and tx_done is ignored unless a byte is
// outstanding. ram_we and ram_re are single-cycle strobes and are never high
// together.
module img_io_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int RX_LEN  = 65536,
  parameter int TX_BASE = 0,
  parameter int TX_LEN  = 16384,
  parameter int RD_LAT  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_done,
  input  logic              start,
  input  logic              cpu_done,
  input  logic              tx_done,
  output logic              tx_start,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic              ram_re,
  output logic              cpu_reset,
  output logic              sel,
  output logic              busy,
  output logic              err,
  output logic [7:0]        dbg_state
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] RX_LAST   = CW'(RX_LEN - 1);
  localparam logic [CW-1:0] TX_LAST   = CW'(TX_LEN - 1);
  localparam logic [CW-1:0] TX_BASE_C = CW'(TX_BASE);
  localparam logic [1:0]    LAT_LAST  = 2'(RD_LAT - 1);

  typedef enum logic [1:0] {M_LOAD, M_PROC, M_DUMP} mode_e;
  typedef enum logic [2:0] {R_IDLE, R_ADDR, R_WE, R_INC, R_WAIT} rx_e;
  typedef enum logic [2:0] {T_IDLE, T_READ, T_LAT, T_SEND, T_WAIT} tx_e;

  mode_e             mode_q, mode_d;
  rx_e               rx_q, rx_d;
  tx_e               tx_q, tx_d;
  logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
  logic [1:0]        lat_q, lat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              txs_q, txs_d;
  logic              load_act_q, load_act_d;
  logic              dump_fin_q, dump_fin_d;
  logic              err_q, err_d;

  logic              load_done;
  logic              dump_done;
  logic              dump_go;
  logic [CW-1:0]     rd_addr;

  assign rd_addr = TX_BASE_C + rd_cnt_q;
  assign dump_go = (mode_q == M_PROC) && cpu_done && start;

  always_comb begin
    mode_d     = mode_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    lat_d      = lat_q;
    addr_d     = addr_q;
    we_d       = 1'b0;
    re_d       = 1'b0;
    txs_d      = 1'b0;
    load_act_d = load_act_q;
    dump_fin_d = dump_fin_q;
    err_d      = err_q;
    load_done  = 1'b0;
    dump_done  = 1'b0;

    // Receive path: one write per rx_done high period, only while loading.
    case (rx_q)
      R_IDLE: begin
        if (rx_done) begin
          if (mode_q == M_LOAD) begin
            addr_d     = wr_cnt_q[ADDR_W-1:0];
            load_act_d = 1'b1;
            rx_d       = R_ADDR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      R_ADDR: begin
        we_d = 1'b1;
        rx_d = R_WE;
      end
      R_WE: begin
        // Completion is taken from the strobe cycle so the CPU owns the RAM
        // the very next cycle.
        if (wr_cnt_q == RX_LAST) load_done = 1'b1;
        rx_d = R_INC;
      end
      R_INC: begin
        wr_cnt_d = (wr_cnt_q == RX_LAST) ? '0 : wr_cnt_q + 1'b1;
        rx_d     = R_WAIT;
      end
      R_WAIT: begin
        if (!rx_done) rx_d = R_IDLE;
      end
      default: rx_d = R_IDLE;
    endcase

    case (tx_q)
      T_IDLE: begin
        if (dump_go) begin
          rd_cnt_d = '0;
          tx_d     = T_READ;
        end
      end
      T_READ: begin
        addr_d = rd_addr[ADDR_W-1:0];
        re_d   = 1'b1;
        lat_d  = 2'd0;
        tx_d   = T_LAT;
      end
      T_LAT: begin
        if (lat_q == LAT_LAST) tx_d = T_SEND;
        else                   lat_d = lat_q + 2'd1;
      end
      T_SEND: begin
        txs_d = 1'b1;
        tx_d  = T_WAIT;
      end
      T_WAIT: begin
        if (tx_done) begin
          if (rd_cnt_q == TX_LAST) begin
            dump_done = 1'b1;
            tx_d      = T_IDLE;
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
            tx_d     = T_READ;
          end
        end
      end
      default: tx_d = T_IDLE;
    endcase

    case (mode_q)
      M_LOAD: begin
        if (load_done) begin
          load_act_d = 1'b0;
          mode_d     = M_PROC;
        end
      end
      M_PROC: begin
        if (dump_go) begin
          dump_fin_d = 1'b0;
          mode_d     = M_DUMP;
        end
      end
      M_DUMP: begin
        if (dump_done) dump_fin_d = 1'b1;
        // A held start keeps the dump mode parked after the last byte.
        if ((dump_fin_q || dump_done) && !start) begin
          dump_fin_d = 1'b0;
          wr_cnt_d   = '0;
          mode_d     = M_LOAD;
        end
      end
      default: mode_d = M_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q     <= M_LOAD;
      rx_q       <= R_IDLE;
      tx_q       <= T_IDLE;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      lat_q      <= 2'd0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      txs_q      <= 1'b0;
      load_act_q <= 1'b0;
      dump_fin_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      lat_q      <= lat_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      re_q       <= re_d;
      txs_q      <= txs_d;
      load_act_q <= load_act_d;
      dump_fin_q <= dump_fin_d;
      err_q      <= err_d;
    end
  end

  assign sel       = (mode_q == M_PROC);
  assign cpu_reset = ~sel;
  assign busy      = load_act_q | (mode_q == M_DUMP);
  assign ram_addr  = addr_q;
  assign ram_we    = we_q;
  assign ram_re    = re_q;
  assign tx_start  = txs_q;
  assign err       = err_q;
  assign dbg_state = {mode_q, rx_q, tx_q};

endmodule
